// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO for the MIPS EX stage.
// Define MDU_FAST_MUL_EN to make MULT/MULTU finish in one cycle; divide stays iterative.
//
//   state | meaning
//   IDLE  | waiting for a mul/div; MTHI/MTLO allowed
//   RUN   | one shift-add or restore step per cycle, WIDTH cycles
//   DONE  | result committed, done_o pulse; MTHI/MTLO allowed
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT state;
    stateT stateNext;

    logic [WIDTH-1:0] hiReg;
    logic [WIDTH-1:0] loReg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] operandB;
    logic [WIDTH-1:0] rawA;
    logic [CW-1:0]    count;
    logic             isDivOp;
    logic             negMain;
    logic             negRem;
    logic             divZero;

    logic             accept;
    logic             lastStep;
    logic             fastPath;
    logic             opSigned;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    assign accept   = (state == IDLE) && start_i && !flush_i;
    assign lastStep = (state == RUN) && (count == CW'(1));
    assign opSigned = ~op_i[0];

    // Negating the most-negative value wraps back to itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign magA = (opSigned && a_i[WIDTH-1]) ? -a_i : a_i;
    assign magB = (opSigned && b_i[WIDTH-1]) ? -b_i : b_i;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fastProd;
    logic [2*WIDTH-1:0] fastFixed;

    assign fastPath  = ~op_i[1];
    assign fastProd  = {{WIDTH{1'b0}}, magA} * {{WIDTH{1'b0}}, magB};
    assign fastFixed = (opSigned && (a_i[WIDTH-1] ^ b_i[WIDTH-1])) ? -fastProd : fastProd;
`else
    assign fastPath = 1'b0;
`endif

    // One datapath step: acc holds the high product / partial remainder,
    // work holds the multiplier being consumed / quotient being built.
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               divFits;
    logic [WIDTH-1:0]   stepAcc;
    logic [WIDTH-1:0]   stepWork;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prodFixed;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    assign mulSum   = {1'b0, acc} + (work[0] ? {1'b0, operandB} : '0);
    assign divShift = {acc, work[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, operandB};
    assign divFits  = ~divDiff[WIDTH];

    always_comb begin
        stepAcc  = mulSum[WIDTH:1];
        stepWork = {mulSum[0], work[WIDTH-1:1]};
        if (isDivOp) begin
            stepAcc  = divFits ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
            stepWork = {work[WIDTH-2:0], divFits};
        end
    end

    assign product   = {stepAcc, stepWork};
    assign prodFixed = negMain ? -product : product;

    always_comb begin
        resHi = prodFixed[2*WIDTH-1:WIDTH];
        resLo = prodFixed[WIDTH-1:0];
        if (isDivOp) begin
            if (divZero) begin
                resHi = rawA;
                resLo = '1;
            end else begin
                resHi = negRem  ? -stepAcc  : stepAcc;
                resLo = negMain ? -stepWork : stepWork;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = fastPath ? DONE : RUN;
                end
            end
            RUN: begin
                if (flush_i) begin
                    stateNext = IDLE;
                end else if (lastStep) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy_o = accept || (state == RUN);
        done_o = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hiReg    <= '0;
            loReg    <= '0;
            acc      <= '0;
            work     <= '0;
            operandB <= '0;
            rawA     <= '0;
            count    <= '0;
            isDivOp  <= 1'b0;
            negMain  <= 1'b0;
            negRem   <= 1'b0;
            divZero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc      <= '0;
                        work     <= magA;
                        operandB <= magB;
                        rawA     <= a_i;
                        isDivOp  <= op_i[1];
                        negMain  <= opSigned && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        negRem   <= opSigned && a_i[WIDTH-1];
                        divZero  <= op_i[1] && (b_i == '0);
                        count    <= fastPath ? '0 : CW'(WIDTH);
                    end
`ifdef MDU_FAST_MUL_EN
                    if (accept && fastPath) begin
                        hiReg <= fastFixed[2*WIDTH-1:WIDTH];
                        loReg <= fastFixed[WIDTH-1:0];
                    end else begin
                        if (wr_hi_i) hiReg <= wdata_i;
                        if (wr_lo_i) loReg <= wdata_i;
                    end
`else
                    if (wr_hi_i) hiReg <= wdata_i;
                    if (wr_lo_i) loReg <= wdata_i;
`endif
                end
                RUN: begin
                    if (flush_i) begin
                        count <= '0;
                    end else begin
                        acc   <= stepAcc;
                        work  <= stepWork;
                        count <= count - CW'(1);
                        if (lastStep) begin
                            hiReg <= resHi;
                            loReg <= resLo;
                        end
                    end
                end
                DONE: begin
                    if (wr_hi_i) hiReg <= wdata_i;
                    if (wr_lo_i) loReg <= wdata_i;
                end
                default: ;
            endcase
        end
    end

    assign hi_o = hiReg;
    assign lo_o = loReg;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: cycle-level reference model plus directed vectors.
// Honours MDU_FAST_MUL_EN so the same bench covers both builds.
module tb_mdu_iter;
    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         wrHi;
    logic         wrLo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int testCount = 0;
    int failCount = 0;
    bit checkEn = 1'b0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .flush_i (flush),
        .wr_hi_i (wrHi),
        .wr_lo_i (wrLo),
        .wdata_i (wdata),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    // Architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        int sx;
        int sy;
        logic [63:0] r;
        sx = x;
        sy = y;
        if (o == 2'b00) begin
            p = longint'(sx) * longint'(sy);
            r = p;
        end else if (o == 2'b01) begin
            p = longint'({32'b0, x}) * longint'({32'b0, y});
            r = p;
        end else if (y == 32'h0) begin
            r = {x, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
            else r = {32'(sx % sy), 32'(sx / sy)};
        end else begin
            r = {x % y, x / y};
        end
        return r;
    endfunction

    // Model state: runLeft > 0 means an iterative op is in flight.
    int          runLeft = 0;
    bit          mDone = 1'b0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic [31:0] pHi = '0;
    logic [31:0] pLo = '0;

    wire [63:0] refNow  = refResult(op, a, b);
    wire        mIdle   = (runLeft == 0) && !mDone;
    wire        accNow  = mIdle && start && !flush;
    wire        fastNow = accNow && FAST && !op[1];
    wire        expBusy = accNow || (runLeft > 0);

    always @(posedge clk) begin
        if (rst) begin
            runLeft <= 0;
            mDone   <= 1'b0;
            mHi     <= '0;
            mLo     <= '0;
        end else if (runLeft > 0) begin
            if (flush) begin
                runLeft <= 0;
            end else if (runLeft == 1) begin
                runLeft <= 0;
                mDone   <= 1'b1;
                mHi     <= pHi;
                mLo     <= pLo;
            end else begin
                runLeft <= runLeft - 1;
            end
        end else begin
            mDone <= 1'b0;
            if (fastNow) begin
                mHi   <= refNow[63:32];
                mLo   <= refNow[31:0];
                mDone <= 1'b1;
            end else begin
                if (accNow) begin
                    runLeft <= W;
                    pHi     <= refNow[63:32];
                    pLo     <= refNow[31:0];
                end
                if (wrHi) mHi <= wdata;
                if (wrLo) mLo <= wdata;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("cyc_busy", {31'b0, busy}, {31'b0, expBusy});
            check("cyc_done", {31'b0, done}, {31'b0, mDone});
            check("cyc_hi", hi, mHi);
            check("cyc_lo", lo, mLo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eHi, input logic [31:0] eLo, input string nm);
        int cyc;
        tick();
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check({nm, "_donecyc"}, cyc, (FAST && !o[1]) ? 32'd1 : 32'(W + 1));
        check({nm, "_hi"}, hi, eHi);
        check({nm, "_lo"}, lo, eLo);
    endtask

    task automatic watchNoDone(input string nm);
        int seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(nm, seen, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; wrHi = 1'b0; wrLo = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);

        runOp(2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg");
        runOp(2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        "divu_100_7");
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, "div_ovf");
        runOp(2'b10, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, "div_zero");
        runOp(2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero_neg");
        runOp(2'b11, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, "divu_zero");
        runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        runOp(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        "mult_minmin");
        runOp(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, "mult_min_m1");
        runOp(2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, "div_7_neg2");
        runOp(2'b11, 32'hFFFF_FFFF, 32'd16,       32'hF,         32'h0FFF_FFFF, "divu_big");

        // start held through DONE: ignored there, accepted in the following IDLE cycle
        tick();
        start = 1'b1; op = 2'b11; a = 32'd200; b = 32'd9;
        for (int i = 0; i < 100 && !done; i++) tick();
        check("b2b_done", {31'b0, done}, 32'h1);
        tick();
        check("b2b_accept_busy", {31'b0, busy}, 32'h1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && !done; i++) tick();
        check("b2b_hi", hi, 32'd2);
        check("b2b_lo", lo, 32'd22);

        // MTHI/MTLO together, then separately
        tick();
        wrHi = 1'b1; wrLo = 1'b1; wdata = 32'h55;
        tick();
        wrHi = 1'b0; wrLo = 1'b0;
        check("mt_both_hi", hi, 32'h55);
        check("mt_both_lo", lo, 32'h55);
        wrHi = 1'b1; wdata = 32'h11;
        tick();
        wrHi = 1'b0; wrLo = 1'b1; wdata = 32'h22;
        tick();
        wrLo = 1'b0;

        // flush at RUN cycle 10, with an MTHI attempt during RUN
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (4) tick();
        wrHi = 1'b1; wdata = 32'h99;
        tick();
        wrHi = 1'b0;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'h0);
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);
        watchNoDone("flush_nodone");
        tick();
        wrLo = 1'b1; wdata = 32'hABCD;
        tick();
        wrLo = 1'b0;
        check("mtlo_after_flush", lo, 32'hABCD);

        // flush wins over start in IDLE
        start = 1'b1; flush = 1'b1; op = 2'b11; a = 32'd9; b = 32'd2;
        @(negedge clk);
        check("idle_flush_busy", {31'b0, busy}, 32'h0);
        tick();
        start = 1'b0; flush = 1'b0;
        watchNoDone("idle_flush_nodone");

        // reset mid-RUN
        tick();
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        watchNoDone("midrst_nodone");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
